// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, insn} pairs between fetch and decode, with redirect flush.
// Optional empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [31:0]           in_pc,
   input  logic [31:0]           in_insn,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [31:0]           out_pc,
   output logic [31:0]           out_insn,
   input  logic                  out_ready,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int                DEPTH    = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

   logic [31:0]           pc_mem_q   [DEPTH];
   logic [31:0]           insn_mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  empty, full, store, drain;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign in_ready = !full && !flush;
   assign count    = count_q;
   // Only stored entries advance the read pointer; a bypassed pair never touches storage.
   assign drain    = !empty && !flush && out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass;
   assign bypass    = empty && in_valid && !flush;
   assign out_valid = (!empty && !flush) || bypass;
   assign out_pc    = !out_valid ? 32'h0 : (bypass ? in_pc   : pc_mem_q[rptr_q]);
   assign out_insn  = !out_valid ? 32'h0 : (bypass ? in_insn : insn_mem_q[rptr_q]);
   assign store     = in_valid && in_ready && !(bypass && out_ready);
`else
   assign out_valid = !empty && !flush;
   assign out_pc    = out_valid ? pc_mem_q[rptr_q]   : 32'h0;
   assign out_insn  = out_valid ? insn_mem_q[rptr_q] : 32'h0;
   assign store     = in_valid && in_ready;
`endif

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (store) wptr_d = wptr_q + PTR_ONE;
      if (drain) rptr_d = rptr_q + PTR_ONE;
      case ({store, drain})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Reset and flush both empty the queue; storage contents are left as-is.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         pc_mem_q[wptr_q]   <= in_pc;
         insn_mem_q[wptr_q] <= in_insn;
      end
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 2, meaning log2 of queue entry count (DEPTH = 2**DEPTH_LOG2, legal range 1..4).
REQ-002 The block SHALL have port clk  input  1  single system clock, all state updates on posedge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port flush  input  1  redirect strobe, same cycle the fetch stage loads a new PC.
REQ-005 The block SHALL have port in_valid  input  1  fetch stage presents a PC/instruction pair.
REQ-006 The block SHALL have port in_pc  input  32  PC of the presented instruction.
REQ-007 The block SHALL have port in_insn  input  32  instruction word fetched at in_pc.
REQ-008 The block SHALL have port in_ready  output  1  queue accepts the pair this cycle.
REQ-009 The block SHALL have port out_valid  output  1  head entry available to decode.
REQ-010 The block SHALL have port out_pc  output  32  PC of head entry.
REQ-011 The block SHALL have port out_insn  output  32  instruction word of head entry.
REQ-012 The block SHALL have port out_ready  input  1  decode consumes head entry this cycle.
REQ-013 The block SHALL have port count  output  DEPTH_LOG2+1  number of stored entries.

Function
REQ-014 The block SHALL be a DEPTH-entry circular FIFO of {pc, insn} pairs with read/write pointers of DEPTH_LOG2 bits wrapping modulo DEPTH.
REQ-015 in_ready SHALL equal (count != DEPTH) && !flush, combinationally.
REQ-016 Push SHALL occur when in_valid && in_ready; entry written at write pointer, pointer +1 on the clock edge.
REQ-017 out_valid SHALL be (count != 0) && !flush; out_pc/out_insn SHALL show the read-pointer entry when out_valid, else 32'h0.
REQ-018 Pop SHALL occur when out_valid && out_ready; read pointer +1 on the clock edge.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 When full, in_ready SHALL be 0 even if out_ready is 1 in that cycle (no full-throughput pass-through).
REQ-021 Pop from empty and push to full SHALL be impossible by construction; count SHALL never exceed DEPTH or underflow.
REQ-022 flush SHALL take priority over all traffic: no push, no pop that cycle; next cycle count=0, both pointers=0, out_valid=0.
REQ-023 A pair presented in the cycle after flush deasserts SHALL be accepted normally (queue empty, in_ready=1).
REQ-024 Ordering SHALL be strict FIFO; pairs SHALL leave in the order accepted, bit-exact.
REQ-025 Storage array contents need not be reset; outputs SHALL never expose them while out_valid=0.

Reset
REQ-026 reset SHALL be sampled only on posedge clk and SHALL override flush and all traffic.
REQ-027 After a reset cycle: count=0, pointers=0, out_valid=0, out_pc=0, out_insn=0, in_ready=1 once reset and flush are low.
REQ-028 reset asserted mid-operation SHALL discard all stored entries; no entry accepted before reset SHALL appear afterwards.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN SHALL select empty-queue bypass.
REQ-030 With FETCH_QUEUE_BYPASS_EN defined: when count=0, in_valid=1, flush=0, out_valid SHALL be 1 combinationally with out_pc=in_pc, out_insn=in_insn; if out_ready=1 the pair is consumed and not stored, else it is stored as normal push.
REQ-031 Without FETCH_QUEUE_BYPASS_EN: push-to-out_valid latency SHALL be exactly 1 cycle; out_* SHALL depend only on registered state and flush.

Verification
REQ-032 Reset then push pc=0x8000_0000/0x8000_0004/0x8000_0008/0x8000_000C with out_ready=0 -> count 1,2,3,4; in_ready=0 at count=4; fifth pair not accepted.
REQ-033 From full (DEPTH=4), out_ready=1 four cycles, in_valid=0 -> out_pc 0x8000_0000,0x8000_0004,0x8000_0008,0x8000_000C in order, then out_valid=0, count=0.
REQ-034 Count=2, in_valid=1 and out_ready=1 for 6 cycles with PCs 0x100+4k -> count stays 2, pointers wrap, outputs emitted in push order without gap.
REQ-035 Count=3, flush=1 with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0 that cycle; next cycle count=0; pc=0x8000_0200 pushed after -> first out_pc=0x8000_0200.
REQ-036 Empty queue, in_pc=0x8000_0010, in_insn=0x0000_0013, out_ready=1 -> bypass build: out_valid same cycle, count stays 0; non-bypass build: out_valid next cycle with same values, count 1 then 0.
REQ-037 Count=3, reset=1 one cycle -> count=0, out_valid=0, out_pc=0, out_insn=0 next cycle; no pre-reset PC observed later.
